c3lib_ckdiv_prog_ctn: RTL and testbench



---
 rtl/c3lib_ckdiv_prog_ctn.sv | 96 +++++++++
 tb/tb_c3lib_ckdiv_prog_ctn.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/c3lib_ckdiv_prog_ctn.sv
// Programmable integer clock divider with a flop-driven, glitch-free output.
// Optional strobe logic is built when C3LIB_CKDIV_PROG_STB_EN is defined.
module c3lib_ckdiv_prog_ctn #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned RESET_RATIO = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             div_ratio_ld,
  output logic             clk_out,
  output logic             clk_out_stb,
  output logic             ratio_ack,
  output logic             busy
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pvld_q, pvld_d;
  logic             clk_q, clk_d;
  logic             ack_q, ack_d;
  logic             wrap;
  logic [DIV_W-1:0] ld_val;
  logic [DIV_W-1:0] half_d;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    act_d  = act_q;
    pend_d = pend_q;
    pvld_d = pvld_q;
    ack_d  = 1'b0;
    // A stopped divider (ratio 0) treats every edge as a period boundary.
    wrap   = (act_q == '0) || (cnt_q == act_q - 1'b1);
    ld_val = (div_ratio == DIV_W'(1)) ? DIV_W'(2) : div_ratio;
    if (wrap) begin
      cnt_d  = '0;
      pvld_d = 1'b0;
      if (div_ratio_ld) begin
        act_d = ld_val;
        ack_d = 1'b1;
      end else if (pvld_q) begin
        act_d = pend_q;
        ack_d = 1'b1;
      end
    end else if (div_ratio_ld) begin
      pend_d = ld_val;
      pvld_d = 1'b1;
    end
    half_d = (act_d >> 1) + DIV_W'(act_d[0]);
    clk_d  = (act_d != '0) && (cnt_d < half_d);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q  <= DIV_W'(RESET_RATIO - 1);
      act_q  <= DIV_W'(RESET_RATIO);
      pend_q <= '0;
      pvld_q <= 1'b0;
      clk_q  <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      pvld_q <= pvld_d;
      clk_q  <= clk_d;
      ack_q  <= ack_d;
    end
  end

  assign clk_out   = clk_q;
  assign ratio_ack = ack_q;
  assign busy      = pvld_q;

`ifdef C3LIB_CKDIV_PROG_STB_EN
  logic             stb_q, stb_d;
  logic [DIV_W-1:0] nxt_ratio;

  // Strobe predicts the following edge: a wrap that lands on a nonzero ratio.
  always_comb begin
    nxt_ratio = pvld_d ? pend_d : act_d;
    stb_d     = ((act_d == '0) || (cnt_d == act_d - 1'b1)) && (nxt_ratio != '0);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) stb_q <= 1'b0;
    else     stb_q <= stb_d;
  end

  assign clk_out_stb = stb_q;
`else
  assign clk_out_stb = 1'b0;
`endif

endmodule

// File: tb/tb_c3lib_ckdiv_prog_ctn.sv
// Scoreboard bench for c3lib_ckdiv_prog_ctn: directed test-plan sequences followed
// by randomized loads and resets, checked against a period-position reference model.
module tb_c3lib_ckdiv_prog_ctn;

  localparam int RR = 8;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] div_ratio = '0;
  logic       div_ratio_ld = 1'b0;
  logic       clk_out, clk_out_stb, ratio_ack, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit clk;
    bit stb;
    bit ack;
    bit busy;
  } exp_t;
  exp_t sb[$];

  // Reference model: active ratio, position in the current output period, pending loads.
  int m_n, m_pos;
  int pq[$];

  c3lib_ckdiv_prog_ctn #(.DIV_W(8), .RESET_RATIO(RR)) dut (
    .clk_in(clk_in), .rst(rst), .div_ratio(div_ratio), .div_ratio_ld(div_ratio_ld),
    .clk_out(clk_out), .clk_out_stb(clk_out_stb), .ratio_ack(ratio_ack), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete (errors so far %0d)", errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  // Monitor: one expectation per clk_in rising edge, sampled on the falling edge.
  always @(negedge clk_in) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("clk_out", int'(clk_out), int'(e.clk));
      check("ratio_ack", int'(ratio_ack), int'(e.ack));
      check("busy", int'(busy), int'(e.busy));
`ifdef C3LIB_CKDIV_PROG_STB_EN
      check("clk_out_stb", int'(clk_out_stb), int'(e.stb));
`else
      check("clk_out_stb", int'(clk_out_stb), 0);
`endif
    end
  end

  function automatic void m_reset();
    m_n = RR;
    m_pos = RR - 1;
    pq.delete();
  endfunction

  function automatic bit m_at_end();
    return (m_n == 0) || (m_pos == m_n - 1);
  endfunction

  function automatic exp_t m_edge(input bit ld, input int v);
    exp_t e;
    int v2;
    int nxt;
    bit applied;
    v2 = (v == 1) ? 2 : v;
    applied = 1'b0;
    if (m_at_end()) begin
      if (ld) begin
        m_n = v2;
        applied = 1'b1;
      end else if (pq.size() > 0) begin
        m_n = pq[0];
        applied = 1'b1;
      end
      pq.delete();
      m_pos = 0;
    end else begin
      m_pos++;
      if (ld) begin
        pq.delete();
        pq.push_back(v2);
      end
    end
    nxt = (pq.size() > 0) ? pq[0] : m_n;
    e.clk  = (m_n != 0) && (m_pos < (m_n + 1) / 2);
    e.ack  = applied;
    e.busy = (pq.size() > 0);
    e.stb  = m_at_end() && (nxt != 0);
    return e;
  endfunction

  // Every stimulus task starts and ends 1 time unit after a falling edge.
  task automatic step(input bit ld, input int v);
    div_ratio_ld = ld;
    div_ratio = 8'(v);
    sb.push_back(m_edge(ld, v));
    @(negedge clk_in);
    #1;
    div_ratio_ld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic run_to_end();
    int guard;
    guard = 0;
    while (!m_at_end() && guard < 300) begin
      step(1'b0, 0);
      guard++;
    end
    check("wrap_reached", int'(m_at_end()), 1);
  endtask

  task automatic reset_mid();
    exp_t z;
    z = '{clk: 1'b0, stb: 1'b0, ack: 1'b0, busy: 1'b0};
    rst = 1'b1;
    div_ratio_ld = 1'b0;
    #1;
    check("async_rst_clk_out", int'(clk_out), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_ack", int'(ratio_ack), 0);
    check("async_rst_stb", int'(clk_out_stb), 0);
    sb.push_back(z);
    @(negedge clk_in);
    #1;
    sb.push_back(z);
    @(negedge clk_in);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    int r;
    int v;
    repeat (3) @(negedge clk_in);
    #1;
    check("reset_clk_out", int'(clk_out), 0);
    check("reset_stb", int'(clk_out_stb), 0);
    check("reset_ack", int'(ratio_ack), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    m_reset();

    idle(20);
    // Odd ratio loaded mid-period.
    idle(3);
    step(1'b1, 5);
    idle(25);
    // Stop, then restart at 3.
    step(1'b1, 0);
    idle(15);
    step(1'b1, 3);
    idle(10);
    // Load landing exactly on the wrap edge.
    run_to_end();
    step(1'b1, 6);
    idle(14);
    // Two loads inside one period: only the last applies.
    run_to_end();
    step(1'b0, 0);
    step(1'b1, 4);
    step(1'b0, 0);
    step(1'b1, 7);
    idle(20);
    // Ratio 1 is clamped to 2.
    step(1'b1, 1);
    idle(12);
    // Reset while ratio 7 runs with 3 pending.
    step(1'b1, 7);
    run_to_end();
    idle(3);
    step(1'b1, 3);
    step(1'b0, 0);
    reset_mid();
    idle(20);

    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        reset_mid();
      end else if (r < 16) begin
        v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 6);
        step(1'b1, v);
      end else begin
        step(1'b0, 0);
      end
    end

    @(negedge clk_in);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
